// File: rtl/ofmap_packer.sv
// Packs a stream of 8-bit rescaled elements into one NUM_BYTES-wide output word
// and hands it off with a valid/ready handshake; single-buffered (FILL/OUT).
module ofmap_packer #(
  parameter int NUM_BYTES = 40,
  parameter int CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic [8*NUM_BYTES-1:0] ofmap_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   clear_i,
  output logic [5:0]             fill_o,
  output logic [CNT_W-1:0]       frame_cnt_o
);

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);

  state_e                 state_q;
  logic [8*NUM_BYTES-1:0] ofmap_q;
  logic [5:0]             fill_q;
  logic                   valid_q;
  logic [CNT_W-1:0]       frame_cnt_q;

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of the others; blocking here would create ordering races.
  // NOTE: the word register is reset too, because its zero state is observable
  // on ofmap_o during and after reset, not merely a don't-care storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      ofmap_q     <= '0;
      fill_q      <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else if (clear_i) begin
      // Abort drops any partial or pending word; the hand-off count survives.
      state_q <= FILL;
      ofmap_q <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (byte_valid_i) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (fill_q == 6'(k)) ofmap_q[8*k +: 8] <= byte_i;
            end
            fill_q <= fill_q + 6'd1;
            if (fill_q == LAST_IDX) begin
              state_q <= OUT;
              valid_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (valid_q && ready_i) begin
            state_q     <= FILL;
            valid_q     <= 1'b0;
            fill_q      <= '0;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Ready comes from state alone so upstream never sees a path from ready_i.
  assign byte_ready_o = (state_q == FILL);
  assign ofmap_o      = ofmap_q;
  assign valid_o      = valid_q;
  assign fill_o       = fill_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_ofmap_packer.sv
// Directed self-checking bench for ofmap_packer with a small in-bench model of
// the expected word, fill level and hand-off count.
module tb_ofmap_packer;

  localparam int NB = 40;
  localparam int CW = 10;
  localparam int W  = 8 * NB;

  logic          clk;
  logic          rst_n;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic [W-1:0]  ofmap_o;
  logic          valid_o;
  logic          ready_i;
  logic          clear_i;
  logic [5:0]    fill_o;
  logic [CW-1:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_word;
  int           exp_fill;
  int           exp_cnt;

  ofmap_packer #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .ofmap_o      (ofmap_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .clear_i      (clear_i),
    .fill_o       (fill_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one edge while the DUT is in FILL.
  task automatic push(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_i       = b;
    step();
    byte_valid_i = 1'b0;
    exp_word[8*exp_fill +: 8] = b;
    exp_fill++;
  endtask

  task automatic check_word(input string tag);
    check({tag, "_word"}, ofmap_o, exp_word);
    check({tag, "_fill"}, W'(fill_o), W'(exp_fill));
  endtask

  initial begin
    rst_n = 1'b1; byte_i = '0; byte_valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
    exp_word = '0; exp_fill = 0; exp_cnt = 0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", W'(byte_ready_o), W'(1));
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_fill",  W'(fill_o), W'(0));
    check("rst_ofmap", ofmap_o, '0);
    check("rst_cnt",   W'(frame_cnt_o), W'(0));
    step();
    rst_n = 1'b1;

    // Back-to-back word 0x01..0x28, ready_i held high
    ready_i = 1'b1;
    for (int i = 0; i < NB; i++) begin
      push(8'(i + 1));
      if (i < NB - 1) check("b2b_valid_low", W'(valid_o), W'(0));
    end
    check("b2b_valid_high", W'(valid_o), W'(1));
    check("b2b_low_byte",  W'(ofmap_o[7:0]), W'(8'h01));
    check("b2b_high_byte", W'(ofmap_o[319:312]), W'(8'h28));
    check_word("b2b");
    step();
    exp_cnt++; exp_fill = 0;
    check("b2b_valid_one_cycle", W'(valid_o), W'(0));
    check("b2b_cnt", W'(frame_cnt_o), W'(exp_cnt));
    check("b2b_fill_zero", W'(fill_o), W'(0));

    // Back-pressure: word held 5 cycles while bytes are offered
    ready_i = 1'b0;
    for (int i = 0; i < NB; i++) push(8'(8'h80 + i));
    byte_valid_i = 1'b1;
    byte_i       = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_byte_ready", W'(byte_ready_o), W'(0));
      check("bp_valid",      W'(valid_o), W'(1));
      check("bp_word",       ofmap_o, exp_word);
      check("bp_fill",       W'(fill_o), W'(NB));
    end
    ready_i = 1'b1;
    step();
    exp_cnt++; exp_fill = 0;
    check("bp_hs_valid", W'(valid_o), W'(0));
    check("bp_hs_fill",  W'(fill_o), W'(0));
    check("bp_hs_cnt",   W'(frame_cnt_o), W'(exp_cnt));
    check("bp_hs_byte0", W'(ofmap_o[7:0]), W'(8'h80));
    step();
    byte_valid_i = 1'b0;
    exp_word[7:0] = 8'hEE; exp_fill = 1;
    check_word("bp_first_accept");

    // Random valid gaps; untouched upper bytes keep the previous word
    for (int i = 1; i < NB; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        check("gap_fill_hold", W'(fill_o), W'(exp_fill));
      end
      push(8'(i * 7 + 3));
      check("gap_fill", W'(fill_o), W'(exp_fill));
    end
    check_word("gap");
    check("gap_valid", W'(valid_o), W'(1));
    step();
    exp_cnt++; exp_fill = 0;
    check("gap_cnt", W'(frame_cnt_o), W'(exp_cnt));

    // Clear after 17 bytes, with a byte offered in the clear cycle
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    check_word("pre_clear");
    clear_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'h99;
    step();
    clear_i = 1'b0; byte_valid_i = 1'b0;
    exp_word = '0; exp_fill = 0;
    check_word("clear");
    check("clear_valid", W'(valid_o), W'(0));
    check("clear_cnt",   W'(frame_cnt_o), W'(exp_cnt));
    for (int i = 0; i < NB; i++) push(8'(i * 3 + 5));
    check_word("post_clear");
    step();
    exp_cnt++; exp_fill = 0;
    check("post_clear_cnt", W'(frame_cnt_o), W'(exp_cnt));

    // Clear while a word is pending drops it uncounted
    ready_i = 1'b0;
    for (int i = 0; i < NB; i++) push(8'(8'hA0 + i));
    check("pend_valid", W'(valid_o), W'(1));
    clear_i = 1'b1; ready_i = 1'b1;
    step();
    clear_i = 1'b0;
    exp_word = '0; exp_fill = 0;
    check_word("pend_clear");
    check("pend_clear_valid", W'(valid_o), W'(0));
    check("pend_clear_ready", W'(byte_ready_o), W'(1));
    check("pend_clear_cnt",   W'(frame_cnt_o), W'(exp_cnt));

    // Asynchronous reset between edges while valid_o is high
    ready_i = 1'b0;
    for (int i = 0; i < NB; i++) push(8'(8'h10 + i));
    check("arst_pre_valid", W'(valid_o), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", W'(valid_o), W'(0));
    check("arst_ready", W'(byte_ready_o), W'(1));
    check("arst_fill",  W'(fill_o), W'(0));
    check("arst_ofmap", ofmap_o, '0);
    check("arst_cnt",   W'(frame_cnt_o), W'(0));
    step();
    rst_n = 1'b1;
    exp_word = '0; exp_fill = 0; exp_cnt = 0;
    ready_i = 1'b1;
    push(8'h5A);
    check_word("arst_first");
    for (int i = 1; i < NB; i++) push(8'(8'h60 + i));
    check_word("arst_word");
    step();
    exp_cnt++; exp_fill = 0;
    check("arst_word_cnt", W'(frame_cnt_o), W'(exp_cnt));

    // Counter wrap: words 2..1025 since reset
    for (int w = 2; w <= 1025; w++) begin
      for (int i = 0; i < NB; i++) push(8'(w + i));
      step();
      exp_fill = 0;
      if (w == 1023) check("wrap_1023", W'(frame_cnt_o), W'(1023));
      if (w == 1024) check("wrap_0",    W'(frame_cnt_o), W'(0));
      if (w == 1025) check("wrap_1",    W'(frame_cnt_o), W'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofmap_packer.md
OFMAP_PACKER -- requirements
Module: ofmap_packer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 40, meaning the number of 8-bit elements per packed output word.
REQ-002 SHALL have parameter CNT_W, default 10, meaning the width of the frame counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port byte_i, input, 8 bits: incoming rescaled element.
REQ-006 SHALL have port byte_valid_i, input, 1 bit: byte_i is valid.
REQ-007 SHALL have port byte_ready_o, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port ofmap_o, output, 8*NUM_BYTES bits: the packed word.
REQ-009 SHALL have port valid_o, output, 1 bit: ofmap_o holds a complete word.
REQ-010 SHALL have port ready_i, input, 1 bit: the downstream consumer accepts ofmap_o.
REQ-011 SHALL have port clear_i, input, 1 bit: synchronous abort/flush.
REQ-012 SHALL have port fill_o, output, 6 bits (sized for NUM_BYTES up to 63): the number of bytes held in the current partial word.
REQ-013 SHALL have port frame_cnt_o, output, CNT_W bits: the number of words handed off.

Function
REQ-014 SHALL implement a two-state FSM with states FILL and OUT; the reset state is FILL.
REQ-015 In FILL, byte_ready_o SHALL be 1; in OUT, byte_ready_o SHALL be 0 (no double buffering).
REQ-016 A byte SHALL be accepted only on a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-017 The k-th accepted byte of a word (k = 0 first) SHALL be written to ofmap_o[8k+7:8k]; fill_o SHALL increment by 1 per accepted byte.
REQ-018 Acceptance of byte k = NUM_BYTES-1 SHALL move the FSM to OUT; valid_o SHALL be 1 from the next cycle, with ofmap_o complete in that same cycle.
REQ-019 In OUT, valid_o and ofmap_o SHALL hold stable until the cycle where valid_o and ready_i are both 1.
REQ-020 On that handshake, the FSM SHALL return to FILL on the next cycle, and fill_o SHALL be 0 on the next cycle.
REQ-021 On that handshake, frame_cnt_o SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-022 ready_i SHALL be ignored in FILL; byte_valid_i SHALL be ignored in OUT.
REQ-023 Minimum throughput SHALL be one word per NUM_BYTES+1 cycles, i.e. back-to-back bytes followed by one OUT cycle with ready_i=1.
REQ-024 ofmap_o bytes not yet written in the current word SHALL retain their previous values; no zero-fill is performed between words.
REQ-025 clear_i=1 SHALL have priority over every other input.
  - Next cycle: FSM in FILL, fill_o=0, valid_o=0, ofmap_o all zero.
  - A byte presented in the same cycle as clear_i SHALL be discarded.
  - A pending output word SHALL be dropped without incrementing frame_cnt_o.
  - frame_cnt_o is unchanged by clear_i.
REQ-026 valid_o SHALL be a registered output with no combinational path from ready_i; byte_ready_o SHALL be decoded from the state register only.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force FSM=FILL, fill_o=0, valid_o=0, ofmap_o=0, frame_cnt_o=0, byte_ready_o=1.
REQ-028 Reset asserted mid-word or in OUT SHALL discard all partial or pending data; the first byte accepted after release SHALL land at index 0.
REQ-029 Reset release SHALL be synchronised externally; the first accept SHALL be possible on the first rising edge after rst_n=1.

Verification
REQ-030 The bench SHALL drive 40 consecutive bytes 0x01..0x28 with ready_i=1 -> valid_o high exactly one cycle, the cycle after the 40th accept; ofmap_o[7:0]=0x01, ofmap_o[319:312]=0x28; frame_cnt_o=1.
REQ-031 The bench SHALL complete a word with ready_i=0 for 5 cycles, then drive byte_valid_i=1 -> byte_ready_o=0 throughout; valid_o and ofmap_o stable; no byte accepted until the cycle after the handshake.
REQ-032 The bench SHALL drive bytes with random byte_valid_i gaps -> the packed word equals the accepted sequence in order; fill_o tracks the accept count exactly.
REQ-033 The bench SHALL assert clear_i after 17 bytes accepted -> fill_o=0 and ofmap_o=0 next cycle, frame_cnt_o unchanged; the next 40 bytes form a correct word.
REQ-034 The bench SHALL complete 1025 words -> frame_cnt_o reads 1023 after word 1023, then 0, then 1.
REQ-035 The bench SHALL assert rst_n=0 asynchronously (between clock edges) while valid_o=1 -> all outputs reach reset values immediately without waiting for a clock edge; after release a new word packs correctly from index 0.
